// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead ready/valid FIFO of arbitrary depth with an explicit
// occupancy register, almost-full/almost-empty compares and synchronous flush.
module sync_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  localparam int unsigned LW        = $clog2(DEPTH + 1),
  localparam int unsigned PW        = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop, mem_we;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake status derives only from the registered level.
  always_comb begin
    wr_ready     = (level_q != LW'(DEPTH));
    rd_valid     = (level_q != '0);
    push         = wr_valid & wr_ready;
    pop          = rd_valid & rd_ready;
    rd_data      = mem_q[rd_ptr_q];
    level        = level_q;
    almost_full  = (level_q >= LW'(AF_LEVEL));
    almost_empty = (level_q <= LW'(AE_LEVEL));
  end

  // Next-state pointers and level; flush discards any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_we   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
        mem_we   = 1'b1;
      end
      if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against a queue-based model.
module tb_sync_fifo;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned WW    = 8;
  localparam int unsigned AFL   = 4;
  localparam int unsigned AEL   = 1;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, wr_valid, rd_ready;
  logic          wr_ready, rd_valid, almost_full, almost_empty;
  logic [WW-1:0] wr_data, rd_data;
  logic [LW-1:0] level;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_on = 1'b0;
  logic [WW-1:0] model_q [$];
  int unsigned pops = 0;
  logic [WW-1:0] last_pop;

  sync_fifo #(
    .DEPTH     (DEPTH),
    .WORD_WIDTH(WW),
    .AF_LEVEL  (AFL),
    .AE_LEVEL  (AEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, advance both.
  task automatic cycle(input logic wv, input logic [WW-1:0] wd, input logic rr,
                       input logic fl, input logic rs);
    int unsigned n;
    bit          do_push, do_pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    rst      = rs;
    #1;
    n = model_q.size();
    if (chk_on) begin
      check("level",        32'(level),        32'(n));
      check("wr_ready",     32'(wr_ready),     32'(n != DEPTH));
      check("rd_valid",     32'(rd_valid),     32'(n != 0));
      check("almost_full",  32'(almost_full),  32'(n >= AFL));
      check("almost_empty", 32'(almost_empty), 32'(n <= AEL));
      if (n != 0) check("rd_data", 32'(rd_data), 32'(model_q[0]));
    end
    if (rs || fl) begin
      model_q.delete();
    end else begin
      do_push = wv && (n < DEPTH);
      do_pop  = rr && (n > 0);
      if (do_pop) begin
        last_pop = model_q.pop_front();
        pops++;
      end
      if (do_push) model_q.push_back(wd);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned p0;
    logic [WW-1:0] prev;
    @(negedge clk);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();

    // Reset mid-stream at level 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, WW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h3F, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h3E, 1'b1, 1'b0, 1'b1);
    idle();

    // Fill and drain.
    for (int i = 0; i < 6; i++) cycle(1'b1, WW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain_order", 32'(last_pop), 32'(8'h10 + i));
    end
    idle();

    // Wrap-around.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, WW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, WW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("wrap_order", 32'(last_pop), 32'(8'hA0 + i));
    end

    // Streaming with 2 words preloaded.
    cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, WW'(i + 2), 1'b1, 1'b0, 1'b0);
      check("stream_seq", 32'(last_pop), 32'(WW'(i)));
    end
    check("stream_pops", pops - p0, 32'd100);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous pop: 0x55 refused, then accepted.
    for (int i = 0; i < 5; i++) cycle(1'b1, WW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("full_last", 32'(last_pop), 32'h55);

    // Flush with concurrent push/pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, WW'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_then_push", 32'(last_pop), 32'h77);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), WW'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) == 0));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO with ready/valid ports on both sides, show-ahead (first-word fall-through) read data, arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It is the general-purpose buffer between producers and consumers in the display pipeline, for example between the pixel/command generator and the LCD serialiser, where upstream back-pressure thresholds are needed.

## Interface
- DEPTH, 4: number of entries; any integer ≥ 2, power of two not required.
- WORD_WIDTH, 8: data width in bits, ≥ 1.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL; range 0..DEPTH-1.
- LW (derived, not overridable): $clog2(DEPTH+1); PW (derived): max(1, $clog2(DEPTH)).

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept a word.
- wr_data  in  WORD_WIDTH  write word.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_ready  in  1  consumer takes rd_data.
- rd_data  out  WORD_WIDTH  oldest stored word (show-ahead).
- level  out  LW  current occupancy, 0..DEPTH.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.

## Operation
- Storage: DEPTH × WORD_WIDTH array; write pointer wr_ptr, read pointer rd_ptr, each PW bits; an explicit LW-bit level register (pointer difference is not used, so non-power-of-two depths work).
- Pointer advance: ptr ← (ptr == DEPTH-1) ? 0 : ptr+1. No other wrap mechanism.
- Push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
- wr_ready = (level != DEPTH); rd_valid = (level != 0). Both depend only on registered state: no combinational path from rd_ready to wr_ready or from wr_valid to rd_valid.
- On push: mem[wr_ptr] ← wr_data, wr_ptr advances. On pop: rd_ptr advances.
- level: push only → +1; pop only → −1; both → unchanged; neither → unchanged.
- rd_data = mem[rd_ptr] combinationally; value is don't-care while rd_valid = 0 and must not be checked then.
- almost_full / almost_empty are compares on the level register; both may be high simultaneously for small DEPTH.
- Priority per edge: rst > flush > push/pop.
- flush (rst low): wr_ptr, rd_ptr, level ← 0; any push or pop in that cycle is discarded (word not stored, no pointer change). Memory contents are not cleared.
- rst: same state as flush. Memory is not reset.
- Producers and consumers must hold wr_data/wr_valid and rd_ready respectively until the handshake; FIFO makes no assumption beyond the standard rule that a valid, once raised, is not withdrawn before accepted.

## Timing
- Reset values (cycle after rst sampled high): wr_ready=1, rd_valid=0, level=0, almost_empty=1, almost_full = (AF_LEVEL == 0 ? 1 : 0) → 0 for legal params.
- Write-to-read latency: word pushed at edge N is visible on rd_data with rd_valid=1 after edge N (one cycle) when FIFO was empty.
- Pop at edge N: next word (if any) on rd_data after edge N; zero bubble under continuous streaming.
- Full (level = DEPTH): wr_ready=0; a pop at edge N raises wr_ready after edge N; a write in the same cycle as that pop is not accepted.
- Empty (level = 0): rd_valid=0; a push that cycle is not readable until after the edge (no combinational bypass).
- Simultaneous push and pop at 0 < level < DEPTH: both accepted, level unchanged, sustained throughput 1 word/cycle.
- Flags and level update on the same edge as the push/pop that changes them.

## Test plan
- Reset/idle (DEPTH=5, WORD_WIDTH=8): assert rst 2 cycles mid-stream with level=3 → next cycle level=0, rd_valid=0, wr_ready=1, almost_empty=1, almost_full=0.
- Fill and drain non-power-of-two: push 0x10..0x14 into DEPTH=5 → wr_ready=0, level=5, almost_full=1 (AF_LEVEL=4 after 4th push); drain → reads 0x10..0x14 in order, rd_valid low after 5th pop.
- Wrap-around: 3 pushes, 3 pops, then 5 pushes 0xA0..0xA4 → pointers wrap past index 4 to 0; reads return 0xA0..0xA4 in order.
- Streaming: wr_valid and rd_ready held high for 100 cycles with incrementing data, FIFO pre-loaded with 2 words → level stays 2, every cycle pops exactly one word, output sequence contiguous.
- Full with simultaneous pop: level=5, wr_valid=1 with 0x55, rd_ready=1 → pop accepted, 0x55 not written, level=4, wr_ready=1 next cycle; 0x55 accepted on following edge.
- Flush with concurrent push/pop: level=3, flush=1, wr_valid=1, rd_ready=1 → next cycle level=0, rd_valid=0; subsequent push 0x77 read back as 0x77 one cycle later.
